// File: rtl/mcb_responder_pkg.sv
// Shared definitions for the MCB user-port responder: instruction encodings,
// controller FSM states and the queued command layout.
package mcb_responder_pkg;

  localparam logic [2:0] INSTR_WR      = 3'b000;
  localparam logic [2:0] INSTR_RD      = 3'b001;
  localparam logic [2:0] INSTR_WR_AP   = 3'b010;
  localparam logic [2:0] INSTR_RD_AP   = 3'b011;
  localparam logic [2:0] INSTR_REFRESH = 3'b100;

  // Beat counter width matches cmd_bl (beats-1, up to 64 beats)
  localparam int unsigned BEAT_W = 6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WR_BURST,
    ST_RD_WAIT,
    ST_RD_BURST
  } state_t;

  typedef struct packed {
    logic [2:0]        instr;
    logic [BEAT_W-1:0] bl;
    logic [29:0]       addr;
  } cmd_t;

  // Refresh has instr[2] set; otherwise instr[0] selects read
  function automatic logic instr_is_refresh(input logic [2:0] instr);
    return instr[2];
  endfunction

  function automatic logic instr_is_read(input logic [2:0] instr);
    return instr[0];
  endfunction

endpackage

// File: rtl/mcb_resp_fifo.sv
// Synchronous first-word-fall-through FIFO with registered count and
// full/empty flags. Pushes when full and pops when empty are ignored.
// The output reads as zero while the FIFO is empty.
module mcb_resp_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_din,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_dout,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CW'(DEPTH));
  assign o_count   = r_count;
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;
  assign o_dout    = o_empty ? '0 : r_mem[r_rptr];

  // Pointer and occupancy tracking
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok) r_wptr <= (r_wptr == AW'(DEPTH - 1)) ? '0 : r_wptr + 1'b1;
      if (w_pop_ok)  r_rptr <= (r_rptr == AW'(DEPTH - 1)) ? '0 : r_rptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage array, written on accepted pushes
  always_ff @(posedge i_clk) begin
    if (w_push_ok) r_mem[r_wptr] <= i_din;
  end

endmodule

// File: rtl/mcb_port_responder.sv
// Block-RAM stand-in for the MIG/MCB user port: accepts cmd/wr/rd FIFO
// handshakes and serves bursts from on-chip memory.
// Optional macro MCB_PORT_RESPONDER_ALIGN_CHECK_EN: commands whose byte
// address is not 8-byte aligned are discarded and flag the sticky error
// of their direction.
module mcb_port_responder
  import mcb_responder_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 64,
  parameter int unsigned MASK_SIZE    = 8,
  parameter int unsigned MEM_WORDS    = 4096,
  parameter int unsigned FIFO_DEPTH   = 64,
  parameter int unsigned CMD_DEPTH    = 4,
  parameter int unsigned CALIB_CYCLES = 16,
  parameter int unsigned READ_LATENCY = 8
) (
  input  logic                  c3_clk0,
  input  logic                  c3_rst0,
  output logic                  c3_calib_done,
  input  logic                  cmd_en,
  input  logic [2:0]            cmd_instr,
  input  logic [5:0]            cmd_bl,
  input  logic [29:0]           cmd_byte_addr,
  output logic                  cmd_empty,
  output logic                  cmd_full,
  input  logic                  wr_en,
  input  logic [MASK_SIZE-1:0]  wr_mask,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_full,
  output logic                  wr_empty,
  output logic [6:0]            wr_count,
  output logic                  wr_underrun,
  output logic                  wr_error,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_full,
  output logic                  rd_empty,
  output logic [6:0]            rd_count,
  output logic                  rd_overflow,
  output logic                  rd_error
);

  localparam int unsigned AW  = $clog2(MEM_WORDS);
  localparam int unsigned CCW = $clog2(CALIB_CYCLES + 1);
  localparam int unsigned WW  = $clog2(READ_LATENCY);

  state_t                  r_state;
  logic                    r_calib_done;
  logic [CCW-1:0]          r_calib_cnt;
  logic [AW-1:0]           r_addr;
  logic [BEAT_W-1:0]       r_bl;
  logic [BEAT_W-1:0]       r_beat;
  logic [WW-1:0]           r_wait;
  logic [DATA_WIDTH-1:0]   r_last_data;
  logic [MASK_SIZE-1:0]    r_last_mask;
  logic                    r_rd_issue;
  logic                    r_wr_underrun;
  logic                    r_wr_error;
  logic                    r_rd_overflow;
  logic                    r_rd_error;
  logic [DATA_WIDTH-1:0]   r_ram_q;
  logic [DATA_WIDTH-1:0]   r_mem [MEM_WORDS];

  cmd_t                    w_cmd_in;
  cmd_t                    w_cmd_q;
  logic [$clog2(CMD_DEPTH):0] w_cmd_count;
  logic                    w_cmd_pop;
  logic [DATA_WIDTH-1:0]   w_wr_q_data;
  logic [MASK_SIZE-1:0]    w_wr_q_mask;
  logic                    w_wr_pop;
  logic                    w_ram_we;
  logic [DATA_WIDTH-1:0]   w_ram_wdata;
  logic [MASK_SIZE-1:0]    w_ram_wmask;
  logic                    w_unused;

  assign c3_calib_done = r_calib_done;
  assign wr_underrun   = r_wr_underrun;
  assign wr_error      = r_wr_error;
  assign rd_overflow   = r_rd_overflow;
  assign rd_error      = r_rd_error;

  assign w_cmd_in  = '{instr: cmd_instr, bl: cmd_bl, addr: cmd_byte_addr};
  assign w_cmd_pop = (r_state == ST_IDLE) && !cmd_empty;
  assign w_wr_pop  = (r_state == ST_WR_BURST) && !wr_empty;

  // An empty wr FIFO on a beat repeats the last popped word and mask
  assign w_ram_we    = (r_state == ST_WR_BURST);
  assign w_ram_wdata = wr_empty ? r_last_data : w_wr_q_data;
  assign w_ram_wmask = wr_empty ? r_last_mask : w_wr_q_mask;

  assign w_unused = ^{w_cmd_q.instr[1], w_cmd_q.addr[29:AW+3],
                      w_cmd_q.addr[2:0], w_cmd_count};

  mcb_resp_fifo #(.WIDTH($bits(cmd_t)), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .i_clk   (c3_clk0),
    .i_rst   (c3_rst0),
    .i_push  (cmd_en && r_calib_done),
    .i_din   (w_cmd_in),
    .i_pop   (w_cmd_pop),
    .o_dout  (w_cmd_q),
    .o_full  (cmd_full),
    .o_empty (cmd_empty),
    .o_count (w_cmd_count)
  );

  mcb_resp_fifo #(.WIDTH(MASK_SIZE + DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_wr_fifo (
    .i_clk   (c3_clk0),
    .i_rst   (c3_rst0),
    .i_push  (wr_en && r_calib_done),
    .i_din   ({wr_mask, wr_data}),
    .i_pop   (w_wr_pop),
    .o_dout  ({w_wr_q_mask, w_wr_q_data}),
    .o_full  (wr_full),
    .o_empty (wr_empty),
    .o_count (wr_count)
  );

  mcb_resp_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_rd_fifo (
    .i_clk   (c3_clk0),
    .i_rst   (c3_rst0),
    .i_push  (r_rd_issue),
    .i_din   (r_ram_q),
    .i_pop   (rd_en && r_calib_done),
    .o_dout  (rd_data),
    .o_full  (rd_full),
    .o_empty (rd_empty),
    .o_count (rd_count)
  );

  // Calibration timer: done rises CALIB_CYCLES edges after reset release
  always_ff @(posedge c3_clk0 or posedge c3_rst0) begin
    if (c3_rst0) begin
      r_calib_cnt  <= '0;
      r_calib_done <= 1'b0;
    end else if (!r_calib_done) begin
      r_calib_cnt <= r_calib_cnt + 1'b1;
      if (r_calib_cnt == CCW'(CALIB_CYCLES - 1)) r_calib_done <= 1'b1;
    end
  end

  // Backing RAM: byte-masked write port and one-cycle registered read
  always_ff @(posedge c3_clk0) begin
    if (w_ram_we) begin
      for (int unsigned b = 0; b < MASK_SIZE; b++) begin
        if (!w_ram_wmask[b]) r_mem[r_addr][b*8 +: 8] <= w_ram_wdata[b*8 +: 8];
      end
    end
    r_ram_q <= r_mem[r_addr];
  end

  // Command sequencer with registered status pulses and sticky errors.
  // A read beat is issued in RD_BURST and pushed one edge later, once the
  // registered RAM output is valid; RD_WAIT therefore lasts READ_LATENCY-2
  // edges so that beats land at pop + READ_LATENCY.
  always_ff @(posedge c3_clk0 or posedge c3_rst0) begin
    if (c3_rst0) begin
      r_state       <= ST_IDLE;
      r_addr        <= '0;
      r_bl          <= '0;
      r_beat        <= '0;
      r_wait        <= '0;
      r_last_data   <= '0;
      r_last_mask   <= '0;
      r_rd_issue    <= 1'b0;
      r_wr_underrun <= 1'b0;
      r_wr_error    <= 1'b0;
      r_rd_overflow <= 1'b0;
      r_rd_error    <= 1'b0;
    end else begin
      r_wr_underrun <= 1'b0;
      r_rd_overflow <= 1'b0;
      r_rd_issue    <= 1'b0;
      if (r_rd_issue && rd_full) begin
        r_rd_overflow <= 1'b1;
        r_rd_error    <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_cmd_pop) begin
            r_addr <= w_cmd_q.addr[AW+2:3];
            r_bl   <= w_cmd_q.bl;
            r_beat <= '0;
            if (instr_is_refresh(w_cmd_q.instr)) begin
              r_state <= ST_IDLE;
`ifdef MCB_PORT_RESPONDER_ALIGN_CHECK_EN
            end else if (w_cmd_q.addr[2:0] != 3'b000) begin
              if (instr_is_read(w_cmd_q.instr)) r_rd_error <= 1'b1;
              else                              r_wr_error <= 1'b1;
`endif
            end else if (instr_is_read(w_cmd_q.instr)) begin
              if (READ_LATENCY > 2) begin
                r_state <= ST_RD_WAIT;
                r_wait  <= WW'(READ_LATENCY - 3);
              end else begin
                r_state <= ST_RD_BURST;
              end
            end else begin
              r_state <= ST_WR_BURST;
            end
          end
        end
        ST_WR_BURST: begin
          r_addr <= r_addr + 1'b1;
          r_beat <= r_beat + 1'b1;
          if (wr_empty) begin
            r_wr_underrun <= 1'b1;
            r_wr_error    <= 1'b1;
          end else begin
            r_last_data <= w_wr_q_data;
            r_last_mask <= w_wr_q_mask;
          end
          if (r_beat == r_bl) r_state <= ST_IDLE;
        end
        ST_RD_WAIT: begin
          if (r_wait == '0) r_state <= ST_RD_BURST;
          else              r_wait  <= r_wait - 1'b1;
        end
        ST_RD_BURST: begin
          r_rd_issue <= 1'b1;
          r_addr     <= r_addr + 1'b1;
          r_beat     <= r_beat + 1'b1;
          if (r_beat == r_bl) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mcb_port_responder.sv
// Directed self-checking bench for mcb_port_responder.
module tb_mcb_port_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        calib_done;
  logic        cmd_en = 1'b0;
  logic [2:0]  cmd_instr = '0;
  logic [5:0]  cmd_bl = '0;
  logic [29:0] cmd_byte_addr = '0;
  logic        cmd_empty, cmd_full;
  logic        wr_en = 1'b0;
  logic [7:0]  wr_mask = '0;
  logic [63:0] wr_data = '0;
  logic        wr_full, wr_empty, wr_underrun, wr_error;
  logic [6:0]  wr_count;
  logic        rd_en = 1'b0;
  logic [63:0] rd_data;
  logic        rd_full, rd_empty, rd_overflow, rd_error;
  logic [6:0]  rd_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mcb_port_responder dut (
    .c3_clk0(clk), .c3_rst0(rst), .c3_calib_done(calib_done),
    .cmd_en(cmd_en), .cmd_instr(cmd_instr), .cmd_bl(cmd_bl),
    .cmd_byte_addr(cmd_byte_addr), .cmd_empty(cmd_empty), .cmd_full(cmd_full),
    .wr_en(wr_en), .wr_mask(wr_mask), .wr_data(wr_data), .wr_full(wr_full),
    .wr_empty(wr_empty), .wr_count(wr_count), .wr_underrun(wr_underrun),
    .wr_error(wr_error), .rd_en(rd_en), .rd_data(rd_data), .rd_full(rd_full),
    .rd_empty(rd_empty), .rd_count(rd_count), .rd_overflow(rd_overflow),
    .rd_error(rd_error)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_cmd(input logic [2:0] instr, input logic [5:0] bl,
                          input logic [29:0] addr);
    cmd_en = 1'b1; cmd_instr = instr; cmd_bl = bl; cmd_byte_addr = addr;
    tick();
    cmd_en = 1'b0;
  endtask

  task automatic push_wr(input logic [63:0] data, input logic [7:0] mask);
    wr_en = 1'b1; wr_data = data; wr_mask = mask;
    tick();
    wr_en = 1'b0; wr_mask = '0;
  endtask

  task automatic pop_rd();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks++; if (calib_done !== 1'b0) begin errors++; $display("FAIL reset_calib got %b exp 0", calib_done); end
    checks++; if ({cmd_empty, wr_empty, rd_empty} !== 3'b111) begin errors++; $display("FAIL reset_empty got %b exp 111", {cmd_empty, wr_empty, rd_empty}); end
    checks++; if ({cmd_full, wr_full, rd_full} !== 3'b000) begin errors++; $display("FAIL reset_full got %b exp 000", {cmd_full, wr_full, rd_full}); end
    checks++; if ({wr_count, rd_count} !== 14'd0) begin errors++; $display("FAIL reset_counts got %0d/%0d exp 0/0", wr_count, rd_count); end
    checks++; if (rd_data !== 64'd0) begin errors++; $display("FAIL reset_rd_data got %h exp 0", rd_data); end
    checks++; if ({wr_underrun, wr_error, rd_overflow, rd_error} !== 4'b0000) begin errors++; $display("FAIL reset_errs got %b exp 0000", {wr_underrun, wr_error, rd_overflow, rd_error}); end
  endtask

  task automatic test_calibration();
    @(negedge clk);
    rst = 1'b0;
    cmd_en = 1'b1; cmd_instr = 3'b001; cmd_bl = 6'd0; cmd_byte_addr = '0;
    wr_en = 1'b1; wr_data = 64'hDEAD;
    repeat (15) tick();
    checks++; if (calib_done !== 1'b0) begin errors++; $display("FAIL calib_early got %b exp 0", calib_done); end
    checks++; if (cmd_empty !== 1'b1) begin errors++; $display("FAIL calib_cmd_ignored got %b exp 1", cmd_empty); end
    checks++; if (wr_empty !== 1'b1) begin errors++; $display("FAIL calib_wr_ignored got %b exp 1", wr_empty); end
    cmd_en = 1'b0; wr_en = 1'b0;
    tick();
    checks++; if (calib_done !== 1'b1) begin errors++; $display("FAIL calib_done got %b exp 1", calib_done); end
    repeat (2) tick();
  endtask

  task automatic test_write_read();
    wr_en = 1'b1;
    for (int i = 0; i < 32; i++) begin
      wr_data = 64'(32'h1000 + i);
      tick();
    end
    wr_en = 1'b0;
    checks++; if (wr_count !== 7'd32) begin errors++; $display("FAIL wr_fill got %0d exp 32", wr_count); end
    push_cmd(3'b010, 6'd31, 30'h100);
    tick();
    checks++; if (wr_count !== 7'd32) begin errors++; $display("FAIL wr_pop_early got %0d exp 32", wr_count); end
    tick();
    checks++; if (wr_count !== 7'd31) begin errors++; $display("FAIL wr_first_beat got %0d exp 31", wr_count); end
    repeat (34) tick();
    checks++; if (wr_empty !== 1'b1 || wr_error !== 1'b0) begin errors++; $display("FAIL wr_done got empty=%b err=%b exp 1/0", wr_empty, wr_error); end
    push_cmd(3'b001, 6'd31, 30'h100);
    repeat (8) tick();
    checks++; if (rd_empty !== 1'b1) begin errors++; $display("FAIL rd_latency_early got %b exp 1", rd_empty); end
    tick();
    checks++; if (rd_empty !== 1'b0 || rd_data !== 64'h1000) begin errors++; $display("FAIL rd_first_beat got empty=%b data=%h exp 0/1000", rd_empty, rd_data); end
    repeat (31) tick();
    checks++; if (rd_count !== 7'd32) begin errors++; $display("FAIL rd_peak got %0d exp 32", rd_count); end
    for (int i = 0; i < 32; i++) begin
      checks++; if (rd_data !== 64'(32'h1000 + i)) begin errors++; $display("FAIL rd_word%0d got %h exp %h", i, rd_data, 32'h1000 + i); end
      pop_rd();
    end
    checks++; if (rd_empty !== 1'b1) begin errors++; $display("FAIL rd_drained got %b exp 1", rd_empty); end
  endtask

  task automatic test_align();
    push_cmd(3'b001, 6'd0, 30'h104);
`ifdef MCB_PORT_RESPONDER_ALIGN_CHECK_EN
    tick();
    checks++; if (cmd_empty !== 1'b1) begin errors++; $display("FAIL align_cmd_popped got %b exp 1", cmd_empty); end
    repeat (11) tick();
    checks++; if (rd_empty !== 1'b1) begin errors++; $display("FAIL align_no_data got %b exp 1", rd_empty); end
    checks++; if ({rd_error, wr_error} !== 2'b10) begin errors++; $display("FAIL align_err got %b exp 10", {rd_error, wr_error}); end
`else
    repeat (12) tick();
    checks++; if (rd_count !== 7'd1 || rd_data !== 64'h1000) begin errors++; $display("FAIL unaligned_read got cnt=%0d data=%h exp 1/1000", rd_count, rd_data); end
    checks++; if (rd_error !== 1'b0) begin errors++; $display("FAIL unaligned_err got %b exp 0", rd_error); end
    pop_rd();
`endif
  endtask

  task automatic test_mask();
    push_wr(64'hFFFF_FFFF_FFFF_FFFF, 8'h00); push_cmd(3'b000, 6'd0, 30'h200); repeat (3) tick();
    push_wr(64'h0, 8'hF0);                   push_cmd(3'b000, 6'd0, 30'h200); repeat (3) tick();
    push_wr(64'hFFFF_FFFF_FFFF_FFFF, 8'h00); push_cmd(3'b000, 6'd0, 30'h208); repeat (3) tick();
    push_wr(64'h0, 8'h0F);                   push_cmd(3'b000, 6'd0, 30'h208); repeat (3) tick();
    push_cmd(3'b011, 6'd1, 30'h200);
    repeat (12) tick();
    checks++; if (rd_count !== 7'd2) begin errors++; $display("FAIL mask_count got %0d exp 2", rd_count); end
    checks++; if (rd_data !== 64'hFFFF_FFFF_0000_0000) begin errors++; $display("FAIL mask_hi_kept got %h exp ffffffff00000000", rd_data); end
    pop_rd();
    checks++; if (rd_data !== 64'h0000_0000_FFFF_FFFF) begin errors++; $display("FAIL mask_lo_kept got %h exp 00000000ffffffff", rd_data); end
    pop_rd();
  endtask

  task automatic test_underrun();
    int pulses;
    logic [63:0] exp;
    for (int i = 0; i < 4; i++) push_wr(64'hA0 + 64'(i), 8'h00);
    push_cmd(3'b000, 6'd7, 30'h400);
    pulses = 0;
    repeat (14) begin
      tick();
      if (wr_underrun === 1'b1) pulses++;
    end
    checks++; if (pulses !== 4) begin errors++; $display("FAIL underrun_pulses got %0d exp 4", pulses); end
    checks++; if (wr_error !== 1'b1) begin errors++; $display("FAIL underrun_sticky got %b exp 1", wr_error); end
    push_cmd(3'b001, 6'd7, 30'h400);
    repeat (18) tick();
    checks++; if (rd_count !== 7'd8) begin errors++; $display("FAIL underrun_rd_count got %0d exp 8", rd_count); end
    for (int i = 0; i < 8; i++) begin
      exp = (i < 4) ? 64'hA0 + 64'(i) : 64'hA3;
      checks++; if (rd_data !== exp) begin errors++; $display("FAIL underrun_word%0d got %h exp %h", i, rd_data, exp); end
      pop_rd();
    end
  endtask

  task automatic test_overflow_wrap();
    int pulses;
    for (int i = 0; i < 4; i++) push_wr(64'hB0 + 64'(i), 8'h00);
    push_cmd(3'b010, 6'd3, 30'h7FF0);
    repeat (8) tick();
    push_cmd(3'b001, 6'd31, 30'h100); repeat (42) tick();
    push_cmd(3'b001, 6'd31, 30'h100); repeat (42) tick();
    checks++; if (rd_count !== 7'd64 || rd_full !== 1'b1) begin errors++; $display("FAIL ovf_fill got cnt=%0d full=%b exp 64/1", rd_count, rd_full); end
    checks++; if (rd_error !== 1'b0) begin errors++; $display("FAIL ovf_err_early got %b exp 0", rd_error); end
    push_cmd(3'b001, 6'd3, 30'h7FF0);
    pulses = 0;
    repeat (14) begin
      tick();
      if (rd_overflow === 1'b1) pulses++;
    end
    checks++; if (pulses !== 4) begin errors++; $display("FAIL ovf_pulses got %0d exp 4", pulses); end
    checks++; if (rd_error !== 1'b1 || rd_count !== 7'd64) begin errors++; $display("FAIL ovf_state got err=%b cnt=%0d exp 1/64", rd_error, rd_count); end
    for (int i = 0; i < 64; i++) begin
      checks++; if (rd_data !== 64'(32'h1000 + (i % 32))) begin errors++; $display("FAIL ovf_drain%0d got %h exp %h", i, rd_data, 32'h1000 + (i % 32)); end
      pop_rd();
    end
    // upper address bits above the RAM index are ignored
    push_cmd(3'b001, 6'd3, 30'h0010_7FF0);
    repeat (12) tick();
    checks++; if (rd_count !== 7'd4) begin errors++; $display("FAIL wrap_count got %0d exp 4", rd_count); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (rd_data !== 64'hB0 + 64'(i)) begin errors++; $display("FAIL wrap_word%0d got %h exp %h", i, rd_data, 64'hB0 + 64'(i)); end
      pop_rd();
    end
  endtask

  task automatic test_reset_abort();
    for (int i = 0; i < 8; i++) push_wr(64'hC0 + 64'(i), 8'h00);
    push_cmd(3'b000, 6'd7, 30'h600);
    repeat (3) tick();
    rst = 1'b1;
    #1;
    checks++; if ({cmd_empty, wr_empty, rd_empty} !== 3'b111 || wr_count !== 7'd0) begin errors++; $display("FAIL abort_empty got %b cnt=%0d exp 111/0", {cmd_empty, wr_empty, rd_empty}, wr_count); end
    checks++; if ({calib_done, wr_error, rd_error} !== 3'b000) begin errors++; $display("FAIL abort_clear got %b exp 000", {calib_done, wr_error, rd_error}); end
    repeat (2) tick();
    rst = 1'b0;
    repeat (2) tick();
  endtask

  initial begin
    test_reset();
    test_calibration();
    test_write_read();
    test_align();
    test_mask();
    test_underrun();
    test_overflow_wrap();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
